// File: rtl/aes_sbox_share_ctrl.sv
// Shares LANES external AES S-box lanes between a 128-bit SubBytes/InvSubBytes
// requester and a 32-bit SubWord requester using round-robin arbitration.
module aes_sbox_share_ctrl #(
    parameter int unsigned LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 blk_req_valid,
    output logic                 blk_req_ready,
    input  logic [127:0]         blk_req_data,
    input  logic                 blk_req_enc,
    output logic                 blk_rsp_valid,
    input  logic                 blk_rsp_ready,
    output logic [127:0]         blk_rsp_data,
    input  logic                 key_req_valid,
    output logic                 key_req_ready,
    input  logic [31:0]          key_req_word,
    output logic                 key_rsp_valid,
    input  logic                 key_rsp_ready,
    output logic [31:0]          key_rsp_word,
    output logic [8*LANES-1:0]   sbox_in,
    output logic                 sbox_enc,
    input  logic [8*LANES-1:0]   sbox_out,
    output logic                 busy
);

    localparam int unsigned NB = 16 / LANES;
    localparam int unsigned KL = (LANES < 4) ? LANES : 4;
    localparam int unsigned NK = 4 / KL;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_BLK_RUN = 3'd1;
    localparam logic [2:0] S_KEY_RUN = 3'd2;
    localparam logic [2:0] S_BLK_RSP = 3'd3;
    localparam logic [2:0] S_KEY_RSP = 3'd4;

    localparam logic GNT_BLK = 1'b0;
    localparam logic GNT_KEY = 1'b1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("aes_sbox_share_ctrl: LANES must be 1, 2, 4, 8 or 16");
    end

    logic [2:0]   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         last_q, last_d;
    logic [127:0] buf_q, buf_d;
    logic         enc_q, enc_d;
    logic [127:0] res_q, res_d;
    logic [31:0]  kres_q, kres_d;
    logic [31:0]  boff, koff;

    assign boff = 32'(cnt_q) * 32'(8 * LANES);
    assign koff = 32'(cnt_q) * 32'(8 * KL);

    assign blk_req_ready = (state_q == S_IDLE) && blk_req_valid
                           && (!key_req_valid || last_q == GNT_KEY);
    assign key_req_ready = (state_q == S_IDLE) && key_req_valid
                           && (!blk_req_valid || last_q == GNT_BLK);
    assign blk_rsp_valid = (state_q == S_BLK_RSP);
    assign key_rsp_valid = (state_q == S_KEY_RSP);
    assign blk_rsp_data  = res_q;
    assign key_rsp_word  = kres_q;
    assign busy          = (state_q != S_IDLE);

    // Key words only ever use the low KL lanes; any lanes above 4 stay at 0.
    always_comb begin
        sbox_in  = '0;
        sbox_enc = 1'b1;
        if (state_q == S_BLK_RUN) begin
            sbox_in  = buf_q[boff +: 8*LANES];
            sbox_enc = enc_q;
        end else if (state_q == S_KEY_RUN) begin
            sbox_in[8*KL-1:0] = buf_q[koff +: 8*KL];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        buf_d   = buf_q;
        enc_d   = enc_q;
        res_d   = res_q;
        kres_d  = kres_q;
        case (state_q)
            S_IDLE: begin
                if (blk_req_ready) begin
                    buf_d   = blk_req_data;
                    enc_d   = blk_req_enc;
                    last_d  = GNT_BLK;
                    cnt_d   = '0;
                    state_d = S_BLK_RUN;
                end else if (key_req_ready) begin
                    buf_d   = {96'b0, key_req_word};
                    enc_d   = 1'b1;
                    last_d  = GNT_KEY;
                    cnt_d   = '0;
                    state_d = S_KEY_RUN;
                end
            end
            S_BLK_RUN: begin
                res_d[boff +: 8*LANES] = sbox_out;
                if (cnt_q == 4'(NB - 1)) begin
                    cnt_d   = '0;
                    state_d = S_BLK_RSP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_KEY_RUN: begin
                kres_d[koff +: 8*KL] = sbox_out[8*KL-1:0];
                if (cnt_q == 4'(NK - 1)) begin
                    cnt_d   = '0;
                    state_d = S_KEY_RSP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_BLK_RSP: if (blk_rsp_ready) state_d = S_IDLE;
            S_KEY_RSP: if (key_rsp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= GNT_KEY;
            buf_q   <= '0;
            enc_q   <= 1'b1;
            res_q   <= '0;
            kres_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            buf_q   <= buf_d;
            enc_q   <= enc_d;
            res_q   <= res_d;
            kres_q  <= kres_d;
        end
    end

endmodule

// File: tb/tb_aes_sbox_share_ctrl.sv
// Bench for aes_sbox_share_ctrl: main instance with LANES=4 plus LANES=1 and
// LANES=16 instances, each wired to a behavioural AES S-box bank.
`timescale 1ns/1ps
module tb_aes_sbox_share_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // ---------------- behavioural S-box ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq, r;
        sq = a; r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] x, input logic enc);
        logic [7:0] b;
        if (enc) begin
            b = ginv(x);
            return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] blk_model(input logic [127:0] d, input logic enc);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_f(d[8*i +: 8], enc);
        return r;
    endfunction

    function automatic logic [31:0] key_model(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_f(w[8*i +: 8], 1'b1);
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- main DUT, LANES=4 ----------------
    localparam int unsigned NB = 4;
    logic         blk_req_valid, blk_req_ready, blk_req_enc, blk_rsp_valid, blk_rsp_ready;
    logic [127:0] blk_req_data, blk_rsp_data;
    logic         key_req_valid, key_req_ready, key_rsp_valid, key_rsp_ready;
    logic [31:0]  key_req_word, key_rsp_word;
    logic [31:0]  sbox_in, sbox_out;
    logic         sbox_enc, busy;

    aes_sbox_share_ctrl #(.LANES(4)) u_dut (
        .clk(clk), .rst(rst),
        .blk_req_valid(blk_req_valid), .blk_req_ready(blk_req_ready),
        .blk_req_data(blk_req_data), .blk_req_enc(blk_req_enc),
        .blk_rsp_valid(blk_rsp_valid), .blk_rsp_ready(blk_rsp_ready), .blk_rsp_data(blk_rsp_data),
        .key_req_valid(key_req_valid), .key_req_ready(key_req_ready), .key_req_word(key_req_word),
        .key_rsp_valid(key_rsp_valid), .key_rsp_ready(key_rsp_ready), .key_rsp_word(key_rsp_word),
        .sbox_in(sbox_in), .sbox_enc(sbox_enc), .sbox_out(sbox_out), .busy(busy)
    );

    always_comb begin
        sbox_out = '0;
        for (int j = 0; j < 4; j++) sbox_out[8*j +: 8] = sbox_f(sbox_in[8*j +: 8], sbox_enc);
    end

    // ---------------- LANES=1 instance ----------------
    logic         a_bv, a_br, a_be, a_rv, a_rr, a_kv, a_kr, a_kvld, a_krr, a_senc, a_busy;
    logic [127:0] a_bd, a_rd;
    logic [31:0]  a_kw, a_kword;
    logic [7:0]   a_sin, a_sout;

    aes_sbox_share_ctrl #(.LANES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .blk_req_valid(a_bv), .blk_req_ready(a_br), .blk_req_data(a_bd), .blk_req_enc(a_be),
        .blk_rsp_valid(a_rv), .blk_rsp_ready(a_rr), .blk_rsp_data(a_rd),
        .key_req_valid(a_kv), .key_req_ready(a_kr), .key_req_word(a_kw),
        .key_rsp_valid(a_kvld), .key_rsp_ready(a_krr), .key_rsp_word(a_kword),
        .sbox_in(a_sin), .sbox_enc(a_senc), .sbox_out(a_sout), .busy(a_busy)
    );
    always_comb a_sout = sbox_f(a_sin, a_senc);

    // ---------------- LANES=16 instance ----------------
    logic         c_bv, c_br, c_be, c_rv, c_rr, c_kv, c_kr, c_kvld, c_krr, c_senc, c_busy;
    logic [127:0] c_bd, c_rd, c_sin, c_sout;
    logic [31:0]  c_kw, c_kword;

    aes_sbox_share_ctrl #(.LANES(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .blk_req_valid(c_bv), .blk_req_ready(c_br), .blk_req_data(c_bd), .blk_req_enc(c_be),
        .blk_rsp_valid(c_rv), .blk_rsp_ready(c_rr), .blk_rsp_data(c_rd),
        .key_req_valid(c_kv), .key_req_ready(c_kr), .key_req_word(c_kw),
        .key_rsp_valid(c_kvld), .key_rsp_ready(c_krr), .key_rsp_word(c_kword),
        .sbox_in(c_sin), .sbox_enc(c_senc), .sbox_out(c_sout), .busy(c_busy)
    );
    always_comb begin
        c_sout = '0;
        for (int j = 0; j < 16; j++) c_sout[8*j +: 8] = sbox_f(c_sin[8*j +: 8], c_senc);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [127:0] data;
        int unsigned  due;   // handshake edge, 0 = not checked
    } exp_t;
    exp_t bq[$];
    exp_t kq[$];
    exp_t bmon, kmon;
    logic bhs_prev = 1'b0;
    logic khs_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            bhs_prev <= 1'b0;
            khs_prev <= 1'b0;
        end else begin
            if (bhs_prev) begin
                check("blk_valid_one_cycle", 128'(blk_rsp_valid), 128'(0));
                check("blk_idle_after_hs", 128'(busy), 128'(0));
            end
            if (khs_prev) begin
                check("key_valid_one_cycle", 128'(key_rsp_valid), 128'(0));
                check("key_idle_after_hs", 128'(busy), 128'(0));
            end
            if (blk_rsp_valid && blk_rsp_ready) begin
                if (bq.size() == 0) check("blk_unexpected_rsp", 128'(1), 128'(0));
                else begin
                    bmon = bq.pop_front();
                    check("blk_data", blk_rsp_data, bmon.data);
                    if (bmon.due != 0) check("blk_latency", 128'(cyc + 1), 128'(bmon.due));
                end
            end
            if (key_rsp_valid && key_rsp_ready) begin
                if (kq.size() == 0) check("key_unexpected_rsp", 128'(1), 128'(0));
                else begin
                    kmon = kq.pop_front();
                    check("key_data", 128'(key_rsp_word), kmon.data);
                    if (kmon.due != 0) check("key_latency", 128'(cyc + 1), 128'(kmon.due));
                end
            end
            bhs_prev <= blk_rsp_valid && blk_rsp_ready;
            khs_prev <= key_rsp_valid && key_rsp_ready;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_blk(input logic [127:0] d, input logic e, input logic [127:0] exp,
                            input bit lat, output int unsigned t);
        int unsigned n = 0;
        @(posedge clk); #1;
        blk_req_valid = 1'b1; blk_req_data = d; blk_req_enc = e;
        @(negedge clk);
        while (!blk_req_ready && n < 200) begin @(negedge clk); n++; end
        check("blk_accept_timeout", 128'(blk_req_ready), 128'(1));
        t = cyc + 1;
        if (blk_req_ready) bq.push_back('{data: exp, due: lat ? t + NB + 1 : 0});
        @(posedge clk); #1;
        blk_req_valid = 1'b0;
        blk_req_data  = {$urandom, $urandom, $urandom, $urandom};
        blk_req_enc   = ~e;
    endtask

    task automatic send_key(input logic [31:0] w, input logic [31:0] exp,
                            input bit lat, output int unsigned t);
        int unsigned n = 0;
        @(posedge clk); #1;
        key_req_valid = 1'b1; key_req_word = w;
        @(negedge clk);
        while (!key_req_ready && n < 200) begin @(negedge clk); n++; end
        check("key_accept_timeout", 128'(key_req_ready), 128'(1));
        t = cyc + 1;
        if (key_req_ready) kq.push_back('{data: {96'b0, exp}, due: lat ? t + 2 : 0});
        @(posedge clk); #1;
        key_req_valid = 1'b0;
        key_req_word  = $urandom;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((bq.size() != 0 || kq.size() != 0) && n < 200) begin @(negedge clk); n++; end
        check("drain_timeout", 128'(bq.size() + kq.size()), 128'(0));
        @(negedge clk);
    endtask

    typedef struct {
        bit           is_key;
        logic [127:0] din;
        logic         enc;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs[8];

    localparam logic [127:0] SEQ_DATA = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] SEQ_FWD  = 128'h76abd7fe2b670130c56f6bf27b777c63;
    localparam logic [127:0] ALL63    = {16{8'h63}};

    int unsigned t, t_b1, t_k1, t_b2, t_k2, nenc0, n;
    logic [127:0] rd;
    logic [31:0]  rw, wexp;
    logic         re, sawv;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        blk_req_valid = 0; blk_req_data = '0; blk_req_enc = 1; blk_rsp_ready = 1;
        key_req_valid = 0; key_req_word = '0; key_rsp_ready = 1;
        a_bv = 0; a_bd = '0; a_be = 1; a_rr = 1; a_kv = 0; a_kw = '0; a_krr = 1;
        c_bv = 0; c_bd = '0; c_be = 1; c_rr = 1; c_kv = 0; c_kw = '0; c_krr = 1;

        vecs[0] = '{1'b0, SEQ_DATA, 1'b1, SEQ_FWD};
        vecs[1] = '{1'b0, ALL63, 1'b0, 128'h0};
        vecs[2] = '{1'b1, 128'h53ff0100, 1'b1, 128'hed167c63};
        for (int i = 3; i < 8; i++) begin
            if (i % 2 == 1) begin
                rw = $urandom;
                vecs[i] = '{1'b1, {96'b0, rw}, 1'b1, {96'b0, key_model(rw)}};
            end else begin
                rd = {$urandom, $urandom, $urandom, $urandom};
                re = 1'($urandom_range(0, 1));
                vecs[i] = '{1'b0, rd, re, blk_model(rd, re)};
            end
        end

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_blk_rsp_valid", 128'(blk_rsp_valid), 128'(0));
        check("rst_key_rsp_valid", 128'(key_rsp_valid), 128'(0));
        check("rst_sbox_in", 128'(sbox_in), 128'(0));
        check("rst_sbox_enc", 128'(sbox_enc), 128'(1));
        check("rst_blk_rsp_data", blk_rsp_data, 128'(0));
        check("rst_key_rsp_word", 128'(key_rsp_word), 128'(0));
        @(posedge clk); #1 rst = 1'b0;

        // contention from reset: strict alternation BLK, KEY, BLK, KEY
        fork
            begin
                send_blk(SEQ_DATA, 1'b1, SEQ_FWD, 1'b1, t_b1);
                send_blk(ALL63, 1'b0, 128'h0, 1'b1, t_b2);
            end
            begin
                send_key(32'h53ff0100, 32'hed167c63, 1'b1, t_k1);
                send_key(32'h00000000, 32'h63636363, 1'b1, t_k2);
            end
        join
        drain();
        check("arb_key1_after_blk1", 128'(t_k1 - t_b1), 128'(6));
        check("arb_blk2_after_key1", 128'(t_b2 - t_k1), 128'(3));
        check("arb_key2_after_blk2", 128'(t_k2 - t_b2), 128'(6));

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_key) send_key(vecs[i].din[31:0], vecs[i].exp[31:0], 1'b1, t);
            else send_blk(vecs[i].din, vecs[i].enc, vecs[i].exp, 1'b1, t);
        end
        drain();

        // inverse direction reaches the lanes only during the run cycles
        send_blk(ALL63, 1'b0, 128'h0, 1'b1, t);
        nenc0 = 0;
        repeat (8) begin
            @(negedge clk);
            if (sbox_enc == 1'b0) nenc0++;
        end
        check("inv_enc_cycles", 128'(nenc0), 128'(4));
        drain();

        // backpressure
        blk_rsp_ready = 1'b0;
        rd = {$urandom, $urandom, $urandom, $urandom};
        send_blk(rd, 1'b1, blk_model(rd, 1'b1), 1'b0, t);
        n = 0;
        while (!blk_rsp_valid && n < 50) begin @(negedge clk); n++; end
        check("bp_valid_timeout", 128'(blk_rsp_valid), 128'(1));
        @(posedge clk); #1;
        blk_req_valid = 1'b1; key_req_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bp_valid_held", 128'(blk_rsp_valid), 128'(1));
            check("bp_data_held", blk_rsp_data, blk_model(rd, 1'b1));
            check("bp_blk_req_ready", 128'(blk_req_ready), 128'(0));
            check("bp_key_req_ready", 128'(key_req_ready), 128'(0));
            check("bp_busy", 128'(busy), 128'(1));
        end
        @(posedge clk); #1;
        blk_req_valid = 1'b0; key_req_valid = 1'b0; blk_rsp_ready = 1'b1;
        drain();

        // reset during chunk 2 of a block
        send_blk(SEQ_DATA, 1'b1, SEQ_FWD, 1'b1, t);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        bq.delete();
        @(posedge clk); @(negedge clk);
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_blk_rsp_valid", 128'(blk_rsp_valid), 128'(0));
        check("midrst_key_rsp_valid", 128'(key_rsp_valid), 128'(0));
        check("midrst_sbox_in", 128'(sbox_in), 128'(0));
        check("midrst_sbox_enc", 128'(sbox_enc), 128'(1));
        check("midrst_blk_rsp_data", blk_rsp_data, 128'(0));
        check("midrst_key_rsp_word", 128'(key_rsp_word), 128'(0));
        @(posedge clk); #1 rst = 1'b0;
        sawv = 1'b0;
        repeat (20) begin
            @(negedge clk);
            sawv = sawv | blk_rsp_valid;
        end
        check("midrst_no_blk_rsp", 128'(sawv), 128'(0));
        send_key(32'h53ff0100, 32'hed167c63, 1'b1, t);
        drain();

        // LANES=1: key takes 4 run cycles, one byte per cycle
        wexp = 32'h53ff0100;
        @(posedge clk); #1 a_kv = 1'b1; a_kw = wexp;
        @(negedge clk);
        check("l1_key_ready", 128'(a_kr), 128'(1));
        @(posedge clk); #1 a_kv = 1'b0; a_kw = 32'hdeadbeef;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("l1_key_lane_in", 128'(a_sin), 128'(wexp[8*k +: 8]));
            check("l1_key_not_yet", 128'(a_kvld), 128'(0));
        end
        @(negedge clk);
        check("l1_key_valid", 128'(a_kvld), 128'(1));
        check("l1_key_word", 128'(a_kword), 128'(32'hed167c63));
        @(negedge clk);
        check("l1_key_drop", 128'(a_kvld), 128'(0));

        // LANES=1: block takes 16 run cycles
        @(posedge clk); #1 a_bv = 1'b1; a_bd = SEQ_DATA; a_be = 1'b1;
        @(negedge clk);
        check("l1_blk_ready", 128'(a_br), 128'(1));
        @(posedge clk); #1 a_bv = 1'b0; a_bd = '0;
        sawv = 1'b0;
        repeat (16) begin
            @(negedge clk);
            sawv = sawv | a_rv;
        end
        check("l1_blk_not_early", 128'(sawv), 128'(0));
        @(negedge clk);
        check("l1_blk_valid", 128'(a_rv), 128'(1));
        check("l1_blk_data", a_rd, SEQ_FWD);

        // LANES=16: key drives lanes 0..3 only, block takes one cycle
        @(posedge clk); #1 c_kv = 1'b1; c_kw = 32'h53ff0100;
        @(negedge clk);
        check("l16_key_ready", 128'(c_kr), 128'(1));
        @(posedge clk); #1 c_kv = 1'b0; c_kw = '0;
        @(negedge clk);
        check("l16_key_lanes", c_sin, 128'h53ff0100);
        check("l16_key_enc", 128'(c_senc), 128'(1));
        check("l16_key_not_yet", 128'(c_kvld), 128'(0));
        @(negedge clk);
        check("l16_key_valid", 128'(c_kvld), 128'(1));
        check("l16_key_word", 128'(c_kword), 128'(32'hed167c63));

        rd = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1 c_bv = 1'b1; c_bd = rd; c_be = 1'b0;
        @(negedge clk);
        check("l16_blk_ready", 128'(c_br), 128'(1));
        @(posedge clk); #1 c_bv = 1'b0; c_bd = '0; c_be = 1'b1;
        @(negedge clk);
        check("l16_blk_lanes", c_sin, rd);
        check("l16_blk_enc", 128'(c_senc), 128'(0));
        @(negedge clk);
        check("l16_blk_valid", 128'(c_rv), 128'(1));
        check("l16_blk_data", c_rd, blk_model(rd, 1'b0));

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
